// File: rtl/banco_registros_param.sv
// Purpose : NREG x DW register bank with half-word writes, two registered read
//           ports that bypass same-cycle writes, and a REP MOVS/STOS/LODS style
//           string engine that steps SI/DI and counts CX down.
// Latency : reads 1 cycle (post-write value); engine addresses update 1 cycle after STR_ACK.
// Backpressure: the engine holds STR_VALID with a stable element until STR_ACK; no timeout.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   WR/WSEL/WHALF/WDATA write port (WHALF 01 low half, 10 high half, else full word)
//   RA/RB -> RDA/RDB    registered read ports
//   STR_START/REP/DF/WORD/ACK  engine control from decode and datapath
//   STR_VALID/SRC/DST/BUSY/DONE, CXZ  engine status towards ALU/BIU
module banco_registros_param #(
   parameter int DW      = 16,
   parameter int NREG    = 8,
   parameter int AW      = 3,
   parameter int CNT_IDX = 1,
   parameter int SRC_IDX = 6,
   parameter int DST_IDX = 7
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          WR,
   input  logic [AW-1:0] WSEL,
   input  logic [1:0]    WHALF,
   input  logic [DW-1:0] WDATA,
   input  logic [AW-1:0] RA,
   input  logic [AW-1:0] RB,
   output logic [DW-1:0] RDA,
   output logic [DW-1:0] RDB,
   input  logic          STR_START,
   input  logic          STR_REP,
   input  logic          STR_DF,
   input  logic          STR_WORD,
   input  logic          STR_ACK,
   output logic          STR_VALID,
   output logic [DW-1:0] STR_SRC,
   output logic [DW-1:0] STR_DST,
   output logic          STR_BUSY,
   output logic          STR_DONE,
   output logic          CXZ
);

   localparam int HW = DW / 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      ITER  = 2'd2,
      DONE  = 2'd3
   } strState_t;

   strState_t state, stateNext;

   logic [DW-1:0] regs     [NREG];
   logic [DW-1:0] regsNext [NREG];

   logic          repLat, dfLat, wordLat;
   logic          protectedSel, wrTaken, stepTaken;
   logic [DW-1:0] wrMerged, stepVal, srcNext, dstNext, cntNext;

   // Merge half writes into the current contents; the half always comes from WDATA low bits.
   always_comb begin
      wrMerged = regs[WSEL];
      case (WHALF)
         2'b01:   wrMerged[HW-1:0]  = WDATA[HW-1:0];
         2'b10:   wrMerged[DW-1:HW] = WDATA[HW-1:0];
         default: wrMerged          = WDATA;
      endcase
   end

   // The engine owns CX/SI/DI while busy, so external writes to them are dropped.
   assign protectedSel = (WSEL == AW'(CNT_IDX)) || (WSEL == AW'(SRC_IDX)) ||
                         (WSEL == AW'(DST_IDX));
   assign wrTaken      = WR && !(STR_BUSY && protectedSel);
   assign stepTaken    = (state == ITER) && STR_ACK;

   assign stepVal = wordLat ? DW'(2) : DW'(1);
   assign srcNext = dfLat ? (regs[SRC_IDX] - stepVal) : (regs[SRC_IDX] + stepVal);
   assign dstNext = dfLat ? (regs[DST_IDX] - stepVal) : (regs[DST_IDX] + stepVal);
   assign cntNext = regs[CNT_IDX] - DW'(1);

   // Next-state view of the whole bank; the read ports sample it so both
   // external writes and engine updates are bypassed to RDA/RDB.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         regsNext[i] = regs[i];
         if (wrTaken && (WSEL == AW'(i))) begin
            regsNext[i] = wrMerged;
         end
      end
      if (stepTaken) begin
         regsNext[SRC_IDX] = srcNext;
         regsNext[DST_IDX] = dstNext;
         if (repLat) begin
            regsNext[CNT_IDX] = cntNext;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
         RDA     <= '0;
         RDB     <= '0;
         repLat  <= 1'b0;
         dfLat   <= 1'b0;
         wordLat <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= regsNext[i];
         end
         RDA <= regsNext[RA];
         RDB <= regsNext[RB];
         if ((state == IDLE) && STR_START) begin
            repLat  <= STR_REP;
            dfLat   <= STR_DF;
            wordLat <= STR_WORD;
         end
      end
   end

   // Engine state register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Engine next-state and status outputs
   always_comb begin
      stateNext = state;
      STR_VALID = 1'b0;
      STR_BUSY  = 1'b1;
      STR_DONE  = 1'b0;
      case (state)
         IDLE: begin
            STR_BUSY = 1'b0;
            if (STR_START) begin
               stateNext = CHECK;
            end
         end
         CHECK: begin
            if (repLat && (regs[CNT_IDX] == '0)) begin
               stateNext = DONE;
            end else begin
               stateNext = ITER;
            end
         end
         ITER: begin
            STR_VALID = 1'b1;
            // CHECK guarantees CX != 0 on entry for REP, so CX == 1 marks the last element.
            if (STR_ACK && (!repLat || (regs[CNT_IDX] == DW'(1)))) begin
               stateNext = DONE;
            end
         end
         DONE: begin
            STR_DONE  = 1'b1;
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   assign STR_SRC = regs[SRC_IDX];
   assign STR_DST = regs[DST_IDX];
   assign CXZ     = (regs[CNT_IDX] == '0);

endmodule
